// File: rtl/epb_wb_pkg.sv
// epb_wb_pkg: FSM states, constants and helpers shared by the EPB-to-Wishbone bridge
package epb_wb_pkg;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CYC  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
    localparam int ERR_CNT_W = 16;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/epb_wb_watchdog.sv
// epb_wb_watchdog: counts cycles while run is high and pulses expired when the count reaches TIMEOUT-1
module epb_wb_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);
    logic [15:0] cnt_q, cnt_d;
    // Restart from zero on clear, otherwise advance while the bus cycle is running
    always_comb begin
        cnt_d   = clr ? '0 : run ? cnt_q + 16'd1 : cnt_q;
        expired = run && !clr && cnt_q == 16'(TIMEOUT - 1);
    end
    // Counter register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/epb_wb_bridge_sync.sv
// epb_wb_bridge_sync: single-clock EPB slave to classic Wishbone master; watchdog built only with EPB_WB_TIMEOUT_EN
module epb_wb_bridge_sync import epb_wb_pkg::*; #(
    parameter int          ADDR_W   = 25,
    parameter int          DATA_W   = 32,
    parameter int          TIMEOUT  = 1024,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic                                  wb_clk_i,
    input  logic                                  wb_rst_i,
    output logic                                  wb_cyc_o,
    output logic                                  wb_stb_o,
    output logic                                  wb_we_o,
    output logic [DATA_W/8-1:0]                   wb_sel_o,
    output logic [ADDR_W+clog2(DATA_W/8)-1:0]     wb_adr_o,
    output logic [DATA_W-1:0]                     wb_dat_o,
    input  logic [DATA_W-1:0]                     wb_dat_i,
    input  logic                                  wb_ack_i,
    input  logic                                  wb_err_i,
    input  logic                                  epb_cs_n,
    input  logic                                  epb_oe_n,
    input  logic                                  epb_r_w_n,
    input  logic [DATA_W/8-1:0]                   epb_be_n,
    input  logic [ADDR_W-1:0]                     epb_addr,
    input  logic [DATA_W-1:0]                     epb_data_i,
    output logic [DATA_W-1:0]                     epb_data_o,
    output logic                                  epb_data_oe_n,
    output logic                                  epb_rdy,
    output logic [ERR_CNT_W-1:0]                  err_cnt
);
    localparam int SEL_W = DATA_W / 8;
    localparam int OFF_W = clog2(SEL_W);
    localparam int BA_W  = ADDR_W + OFF_W;

    if (!(DATA_W inside {8, 16, 32, 64}) || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_param
        $error("epb_wb_bridge_sync: unsupported DATA_W or TIMEOUT");
    end

    logic [1:0]           state_q, state_d;
    logic                 cyc_q, cyc_d, we_q, we_d, prev_cs_n_q;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [BA_W-1:0]      adr_q, adr_d;
    logic [DATA_W-1:0]    dat_q, dat_d, rdata_q, rdata_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 start, expired, fail, done;

    assign start = state_q == S_IDLE && prev_cs_n_q && !epb_cs_n;

`ifdef EPB_WB_TIMEOUT_EN
    epb_wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clr     (start),
        .run     (state_q == S_CYC),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    assign fail = wb_err_i || expired;
    assign done = state_q == S_CYC && (fail || wb_ack_i);

    // Next-state logic: latch host fields at start, terminate on ack/err/timeout, then handshake with the host
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rdata_d   = rdata_q;
        err_cnt_d = err_cnt_q;
        if (start) begin
            state_d = S_CYC;
            cyc_d   = 1'b1;
            we_d    = !epb_r_w_n;
            sel_d   = ~epb_be_n;
            adr_d   = BA_W'(epb_addr) << OFF_W;
            dat_d   = epb_data_i;
        end
        if (done) begin
            state_d   = S_RESP;
            cyc_d     = 1'b0;
            rdata_d   = we_q ? rdata_q : fail ? DATA_W'(ERR_DATA) : wb_dat_i;
            err_cnt_d = fail && err_cnt_q != '1 ? err_cnt_q + 1'b1 : err_cnt_q;
        end
        if (state_q == S_RESP) state_d = epb_cs_n ? S_IDLE : S_HOLD;
        if (state_q == S_HOLD && epb_cs_n) state_d = S_IDLE;
    end

    // State and datapath registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rdata_q     <= '0;
            err_cnt_q   <= '0;
            prev_cs_n_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rdata_q     <= rdata_d;
            err_cnt_q   <= err_cnt_d;
            prev_cs_n_q <= epb_cs_n;
        end
    end

    // Outputs: rdy pulses only when the host is still selected in RESP; the pad drives only for reads in HOLD
    always_comb begin
        wb_cyc_o      = cyc_q;
        wb_stb_o      = cyc_q;
        wb_we_o       = we_q;
        wb_sel_o      = sel_q;
        wb_adr_o      = adr_q;
        wb_dat_o      = dat_q;
        epb_data_o    = rdata_q;
        err_cnt       = err_cnt_q;
        epb_rdy       = state_q == S_RESP && !epb_cs_n;
        epb_data_oe_n = !(state_q == S_HOLD && !epb_cs_n && !we_q && !epb_oe_n);
    end
endmodule

// File: tb/tb_epb_wb_bridge_sync.sv
// tb_epb_wb_bridge_sync: scoreboard bench for the EPB-to-Wishbone bridge (DATA_W=32, TIMEOUT=8)
module tb_epb_wb_bridge_sync;
    localparam int AW = 25;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int BW = 27;
    localparam int TO = 8;
`ifdef EPB_WB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cyc, stb, we;
    logic [SW-1:0] sel;
    logic [BW-1:0] adr;
    logic [DW-1:0] dat_o;
    logic [DW-1:0] dat_i = '0;
    logic          ack = 1'b0, err = 1'b0;
    logic          cs_n = 1'b1, oe_n = 1'b1, r_w_n = 1'b1;
    logic [SW-1:0] be_n = '1;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data_i = '0;
    logic [DW-1:0] data_o;
    logic          data_oe_n, rdy;
    logic [15:0]   err_cnt;

    always #5 clk = ~clk;

    epb_wb_bridge_sync #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) u_dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wb_cyc_o      (cyc),
        .wb_stb_o      (stb),
        .wb_we_o       (we),
        .wb_sel_o      (sel),
        .wb_adr_o      (adr),
        .wb_dat_o      (dat_o),
        .wb_dat_i      (dat_i),
        .wb_ack_i      (ack),
        .wb_err_i      (err),
        .epb_cs_n      (cs_n),
        .epb_oe_n      (oe_n),
        .epb_r_w_n     (r_w_n),
        .epb_be_n      (be_n),
        .epb_addr      (addr),
        .epb_data_i    (data_i),
        .epb_data_o    (data_o),
        .epb_data_oe_n (data_oe_n),
        .epb_rdy       (rdy),
        .err_cnt       (err_cnt)
    );

    typedef struct {
        logic          we;
        logic [BW-1:0] adr;
        logic [SW-1:0] sel;
        logic [DW-1:0] dat;
        int            len;
    } req_t;
    typedef struct {
        logic [DW-1:0] rdata;
        logic [15:0]   errs;
    } rsp_t;

    req_t          req_q[$];
    rsp_t          rsp_q[$];
    req_t          cur;
    int            n_tests = 0;
    int            n_fail = 0;
    int            cyc_len = 0;
    logic          cyc_prev = 1'b0;
    logic [15:0]   exp_err = '0;
    logic [DW-1:0] last_rd = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: pops the request scoreboard when cyc rises and the response scoreboard on each rdy pulse
    always @(negedge clk) begin
        if (rst) begin
            cyc_len  = 0;
            cyc_prev = 1'b0;
        end else begin
            if (cyc && !cyc_prev) begin
                if (req_q.size() == 0) check("cyc_unexpected", 1, 0);
                else cur = req_q.pop_front();
            end
            if (cyc) begin
                cyc_len++;
                check("stb", stb, 1);
                check("we", we, cur.we);
                check("adr", adr, cur.adr);
                check("sel", sel, cur.sel);
                check("dat_o", dat_o, cur.dat);
            end
            if (!cyc && cyc_prev) begin
                check("cyc_len", cyc_len, cur.len);
                cyc_len = 0;
            end
            if (rdy) begin
                if (rsp_q.size() == 0) check("rdy_unexpected", 1, 0);
                else begin
                    rsp_t s;
                    s = rsp_q.pop_front();
                    check("rdata", data_o, s.rdata);
                    check("err_cnt", err_cnt, s.errs);
                end
            end
            cyc_prev = cyc;
        end
    end

    task automatic xfer(input logic [AW-1:0] a, input logic rd, input logic [SW-1:0] bn,
                        input logic [DW-1:0] wd, input logic [DW-1:0] sd, input int dly,
                        input logic e, input bit abort);
        req_t r;
        rsp_t s;
        bit   to;
        int   t;
        to    = TO_EN && (dly < 0 || dly >= TO - 1);
        r.we  = !rd;
        r.adr = {a, 2'b00};
        r.sel = ~bn;
        r.dat = wd;
        r.len = to ? TO : dly + 1;
        if (to || e) begin
            exp_err++;
            if (rd) last_rd = 32'hDEAD_BEEF;
        end else if (rd) last_rd = sd;
        s.rdata = last_rd;
        s.errs  = exp_err;
        req_q.push_back(r);
        if (!abort) rsp_q.push_back(s);
        @(posedge clk) #1;
        cs_n = 1'b0; r_w_n = rd; be_n = bn; addr = a; data_i = wd;
        for (t = 0; t < 10 && !cyc; t++) @(negedge clk);
        check("cyc_start", cyc, 1);
        if (abort) #1 cs_n = 1'b1;
        if (!to) begin
            repeat (dly) @(posedge clk);
            #1;
            ack = 1'b1; err = e; dat_i = sd;
            @(posedge clk) #1;
            ack = 1'b0; err = 1'b0;
        end else
            for (t = 0; t < 20 && cyc; t++) @(negedge clk);
        if (abort) begin
            repeat (4) @(negedge clk);
            check("abort_idle_cyc", cyc, 0);
            return;
        end
        for (t = 0; t < 10 && !rdy; t++) @(negedge clk);
        check("rdy_seen", rdy, 1);
        @(posedge clk) #1 oe_n = 1'b0;
        @(negedge clk);
        check("hold_oe_n", data_oe_n, rd ? 0 : 1);
        check("hold_data", data_o, last_rd);
        @(posedge clk) #1;
        cs_n = 1'b1; oe_n = 1'b1;
        @(negedge clk);
        check("release_oe_n", data_oe_n, 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cyc"}, cyc, 0);
        check({tag, "_stb"}, stb, 0);
        check({tag, "_we"}, we, 0);
        check({tag, "_sel"}, sel, 0);
        check({tag, "_adr"}, adr, 0);
        check({tag, "_dat_o"}, dat_o, 0);
        check({tag, "_data_o"}, data_o, 0);
        check({tag, "_oe_n"}, data_oe_n, 1);
        check({tag, "_rdy"}, rdy, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got hang expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        int t;
        req_t r;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");
        xfer(25'h000010, 1'b1, 4'b0000, 32'h0, 32'h1234_5678, 3, 1'b0, 1'b0);
        xfer(25'h000123, 1'b0, 4'b1100, 32'hAABB_CCDD, 32'h0, 0, 1'b0, 1'b0);
        xfer(25'h1ABCDEF, 1'b1, 4'b0000, 32'h0, 32'h5555_AAAA, 1, 1'b1, 1'b0);
        xfer(25'h0000FF, 1'b1, 4'b0101, 32'h0, 32'h0BAD_F00D, TO_EN ? -1 : 1000, 1'b0, 1'b0);
        xfer(25'h000042, 1'b1, 4'b0000, 32'h0, 32'h7777_7777, 2, 1'b0, 1'b1);
        xfer(25'h000043, 1'b1, 4'b0011, 32'h0, 32'hCAFE_0001, 1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            xfer(AW'($urandom), 1'($urandom_range(0, 1)), SW'($urandom), $urandom, $urandom,
                 $urandom_range(0, 3), 1'b0, 1'b0);
        r.we = 1'b0; r.adr = {25'h000500, 2'b00}; r.sel = 4'hF; r.dat = 32'h0; r.len = 0;
        req_q.push_back(r);
        @(posedge clk) #1;
        cs_n = 1'b0; r_w_n = 1'b1; be_n = 4'b0000; addr = 25'h000500; data_i = 32'h0;
        for (t = 0; t < 10 && !cyc; t++) @(negedge clk);
        check("rst_cyc_start", cyc, 1);
        @(posedge clk) #1 rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0; cs_n = 1'b1;
        exp_err = '0;
        last_rd = '0;
        @(negedge clk);
        check_reset_state("midrst");
        xfer(25'h000777, 1'b0, 4'b0000, 32'h0102_0304, 32'h0, 1, 1'b0, 1'b0);
        xfer(25'h000778, 1'b1, 4'b0000, 32'h0, 32'h8765_4321, 0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("req_q_empty", req_q.size(), 0);
        check("rsp_q_empty", rsp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/epb_wb_bridge_sync.md
Name: epb_wb_bridge_sync

Overview:
- Single-clock, parametrised EPB-slave to Wishbone-master bridge. It is the successor to the dual-clock EPB bridge.
- The EPB strobes are already synchronised to wb_clk_i upstream, so the block contains no CDC handshake.
- Over the previous generation it adds:
  - address, data and byte-lane parametrisation;
  - host-side fields latched at transaction start;
  - classic Wishbone cyc/stb held until termination;
  - error-data substitution;
  - a saturating error counter.
- It sits between the EPB pad/synchroniser logic and the system Wishbone interconnect.

Parameters:
- ADDR_W, 25, EPB word-address width.
- DATA_W, 32, data width; must be 8, 16, 32 or 64.
- TIMEOUT, 1024, Wishbone watchdog limit in wb_clk_i cycles; range 2..65535; used only with the optional feature.
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error or timeout; truncated or zero-extended to DATA_W.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe; always equal to wb_cyc_o.
- wb_we_o  out  1  write enable.
- wb_sel_o  out  DATA_W/8  byte selects.
- wb_adr_o  out  ADDR_W+log2(DATA_W/8)  byte address; word address with the low bits zero.
- wb_dat_o  out  DATA_W  write data.
- wb_dat_i  in  DATA_W  read data.
- wb_ack_i  in  1  acknowledge.
- wb_err_i  in  1  error.
- epb_cs_n  in  1  chip select, active low.
- epb_oe_n  in  1  output enable, active low.
- epb_r_w_n  in  1  1 = read, 0 = write.
- epb_be_n  in  DATA_W/8  byte enables, active low.
- epb_addr  in  ADDR_W  word address.
- epb_data_i  in  DATA_W  host write data.
- epb_data_o  out  DATA_W  host read data.
- epb_data_oe_n  out  1  data pad drive enable, active low.
- epb_rdy  out  1  single-cycle transfer-complete pulse.
- err_cnt  out  16  saturating count of error and timeout terminations.

Behaviour:
- Reset (synchronous, active-high, on wb_clk_i):
  - State = IDLE.
  - wb_cyc_o = 0; wb_we_o = 0; wb_sel_o = 0; wb_adr_o = 0; wb_dat_o = 0.
  - epb_data_o = 0; epb_data_oe_n = 1; epb_rdy = 0; err_cnt = 0.
  - prev_cs_n = 1.
  - Reset mid-cycle drops wb_cyc_o on the next edge, and no epb_rdy is issued.
- Start detection: transaction start = prev_cs_n & ~epb_cs_n, evaluated in IDLE only. Starts seen in any other state are ignored.
- IDLE -> CYC on start. At that edge the following are latched:
  - wb_adr_o <= {epb_addr, zeros};
  - wb_sel_o <= ~epb_be_n;
  - wb_we_o <= ~epb_r_w_n;
  - wb_dat_o <= epb_data_i;
  - wb_cyc_o <= 1, giving a latency of 1 cycle from the start edge to cyc.
- CYC state:
  - wb_cyc_o and wb_stb_o stay high, with address, select, write-enable and data stable, until termination.
  - On wb_ack_i: epb_data_o <= wb_dat_i, captured for reads only; cyc <= 0; go to RESP.
  - On wb_err_i: epb_data_o <= ERR_DATA, for reads only; err_cnt++; cyc <= 0; go to RESP.
  - Simultaneous ack and err is treated as err.
- RESP state (one cycle):
  - If epb_cs_n is still 0: epb_rdy = 1 for exactly this cycle; go to HOLD.
  - If epb_cs_n is 1 (host aborted): no epb_rdy pulse; go to IDLE.
- HOLD state:
  - For reads, epb_data_oe_n = epb_oe_n. For writes it stays 1.
  - When epb_cs_n = 1: epb_data_oe_n <= 1; go to IDLE.
- epb_cs_n rising during CYC does not abort the Wishbone cycle. The cycle completes, then the RESP abort rule above applies.
- err_cnt saturates at 16'hFFFF and is cleared only by reset.
- Back-to-back transfers: the minimum spacing is one cycle of cs_n high, giving a new start edge after return to IDLE.

Optional Feature:
- Macro: EPB_WB_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in CYC, cleared on entry to CYC.
  - When the count reaches TIMEOUT-1 with no ack or err, the block terminates the cycle exactly as for wb_err_i: ERR_DATA substituted on reads, err_cnt++, cyc dropped, go to RESP.
  - A termination on the same cycle the watchdog fires counts once.
- Undefined:
  - No counter is built, and the block waits in CYC indefinitely.
  - The TIMEOUT parameter is ignored.

Decomposition:
- Package epb_wb_pkg holds:
  - the state enumeration (IDLE, CYC, RESP, HOLD);
  - the ERR_DATA default constant;
  - the err_cnt width constant (16);
  - a clog2 function for the byte-offset width.
- One sub-module, epb_wb_watchdog:
  - Inputs: clock, reset, clear, run.
  - Output: expired pulse.
  - Instantiated only under EPB_WB_TIMEOUT_EN.

Test Plan:
- Read, DATA_W=32: cs_n falls with addr=0x000010, r_w_n=1, be_n=0; slave acks 3 cycles after cyc with dat_i=0x12345678.
  - Expect: wb_adr_o=0x40, wb_sel_o=0xF, cyc high for 4 cycles, one epb_rdy pulse, epb_data_o=0x12345678 driven while oe_n=0.
- Write with byte lanes: data_i=0xAABBCCDD, be_n=4'b1100, r_w_n=0; immediate ack.
  - Expect: wb_we_o=1, wb_sel_o=0x3, wb_dat_o=0xAABBCCDD, epb_data_oe_n stays 1, epb_rdy pulse.
- Error termination: read with wb_err_i and wb_ack_i asserted together.
  - Expect: epb_data_o=0xDEADBEEF, err_cnt=1, epb_rdy pulse.
- Timeout (EPB_WB_TIMEOUT_EN defined, TIMEOUT=8): slave never responds.
  - Expect: cyc drops after 8 cycles, ERR_DATA returned, err_cnt increments.
  - With the macro undefined, cyc stays high for 1000 cycles.
- Host abort: cs_n rises while in CYC, then ack arrives.
  - Expect: no epb_rdy pulse, return to IDLE, the next start is accepted normally.
- Reset mid-cycle: assert wb_rst_i during CYC.
  - Expect: cyc=0 and all outputs at reset values the next cycle; err_cnt=0; a later transfer completes.
